// File: rtl/nmi_demux_if.sv
// NMI bus interface: single-beat request/response handshake (valid/ready, addr, wdata, wstrb, rdata).
interface nmi_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/nmi_demux.sv
// NMI address demultiplexer: decodes one upstream NMI port onto SLV_NUM slaves with decode-error response.
// Optional BUSY watchdog (counter, TOUT state) is built only when NMI_DEMUX_TIMEOUT_EN is defined.
module nmi_demux #(
  parameter int unsigned           SLV_NUM     = 13,
  parameter logic [SLV_NUM*32-1:0] ADDR_BASE   = '0,
  parameter logic [SLV_NUM*32-1:0] ADDR_MASK   = '0,
  parameter int unsigned           TIMEOUT_CYC = 1024,
  parameter logic [31:0]           ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  nmi_if.slave                  nmi,
  output logic [SLV_NUM-1:0]    s_valid_o,
  output logic [31:0]           s_addr_o,
  output logic [31:0]           s_wdata_o,
  output logic [3:0]            s_wstrb_o,
  input  logic [SLV_NUM-1:0]    s_ready_i,
  input  logic [SLV_NUM*32-1:0] s_rdata_i,
  output logic                  err_o,
  output logic [1:0]            err_type_o,
  output logic [31:0]           err_addr_o
);

  localparam int unsigned SEL_W = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DERR = 2'd2,
    ST_TOUT = 2'd3
  } state_e;

  if (SLV_NUM < 1 || SLV_NUM > 16) begin : g_bad_slv_num
    $error("nmi_demux: SLV_NUM must be in 1..16");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("nmi_demux: TIMEOUT_CYC must be at least 2");
  end

  state_e              r_state;
  state_e              w_state_nxt;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    w_idx;
  logic                w_hit;
  logic [SLV_NUM-1:0]  w_match;
  logic [31:0]         w_rdata_arr [SLV_NUM];
  logic                w_sel_ready;
  logic [31:0]         w_sel_rdata;
  logic                w_tout;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic [SLV_NUM-1:0]  r_s_valid;
  logic                r_err;
  logic [1:0]          r_err_type;
  logic [31:0]         r_err_addr;

  for (genvar g = 0; g < SLV_NUM; g++) begin : g_slv
    assign w_match[g]     = (nmi.addr & ADDR_MASK[g*32 +: 32]) == ADDR_BASE[g*32 +: 32];
    assign w_rdata_arr[g] = s_rdata_i[g*32 +: 32];
  end

  // Priority encode: scanning downward leaves the lowest matching slave in w_idx.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = SLV_NUM - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit = 1'b1;
        w_idx = SEL_W'(i);
      end
    end
  end

  assign w_sel_ready = s_ready_i[r_sel];
  assign w_sel_rdata = w_rdata_arr[r_sel];

`ifdef NMI_DEMUX_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] r_cnt;

  // Counts stalled BUSY cycles; held at zero in every other state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (r_state != ST_BUSY) begin
      r_cnt <= '0;
    end else if (!w_sel_ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_tout = (r_state == ST_BUSY) && !w_sel_ready && (r_cnt == CNT_W'(TIMEOUT_CYC - 2));
`else
  assign w_tout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Slave ready wins over the terminal count.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (nmi.valid) w_state_nxt = w_hit ? ST_BUSY : ST_DERR;
      ST_BUSY: begin
        if (w_sel_ready) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tout) begin
          w_state_nxt = ST_TOUT;
        end
      end
      ST_DERR: w_state_nxt = ST_IDLE;
      ST_TOUT: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    nmi.ready = 1'b0;
    nmi.rdata = '0;
    case (r_state)
      ST_BUSY: begin
        if (w_sel_ready) begin
          nmi.ready = 1'b1;
          nmi.rdata = w_sel_rdata;
        end
      end
      ST_DERR, ST_TOUT: begin
        nmi.ready = 1'b1;
        nmi.rdata = ERR_RDATA;
      end
      default: ;
    endcase
  end

  // Request capture, one-hot slave select and error reporting.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_sel      <= '0;
      r_s_valid  <= '0;
      r_err      <= 1'b0;
      r_err_type <= 2'b00;
      r_err_addr <= '0;
    end else begin
      r_err <= 1'b0;
      if (r_state == ST_IDLE && nmi.valid) begin
        r_addr  <= nmi.addr;
        r_wdata <= nmi.wdata;
        r_wstrb <= nmi.wstrb;
        r_sel   <= w_idx;
      end
      if (w_state_nxt != ST_BUSY) begin
        r_s_valid <= '0;
      end else if (r_state == ST_IDLE) begin
        r_s_valid <= SLV_NUM'(1) << w_idx;
      end
      if (w_state_nxt == ST_DERR) begin
        r_err      <= 1'b1;
        r_err_type <= 2'b01;
        r_err_addr <= nmi.addr;
      end else if (w_state_nxt == ST_TOUT) begin
        r_err      <= 1'b1;
        r_err_type <= 2'b10;
        r_err_addr <= r_addr;
      end
    end
  end

  assign s_valid_o  = r_s_valid;
  assign s_addr_o   = r_addr;
  assign s_wdata_o  = r_wdata;
  assign s_wstrb_o  = r_wstrb;
  assign err_o      = r_err;
  assign err_type_o = r_err_type;
  assign err_addr_o = r_err_addr;

endmodule

// File: tb/tb_nmi_demux.sv
// Self-checking bench for nmi_demux: randomized slave behaviour checked against a transaction-level model.
module tb_nmi_demux;
  localparam int unsigned SLV_NUM     = 3;
  localparam int unsigned TIMEOUT_CYC = 8;
  localparam logic [31:0] ERR_RD      = 32'hDEAD_BEEF;
`ifdef NMI_DEMUX_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_CYC - 1;
`else
  localparam int TO_LIMIT = 1 << 30;
`endif

  logic                  clk;
  logic                  rst_n;
  logic [SLV_NUM-1:0]    s_valid;
  logic [31:0]           s_addr;
  logic [31:0]           s_wdata;
  logic [3:0]            s_wstrb;
  logic [SLV_NUM-1:0]    s_ready;
  logic [SLV_NUM*32-1:0] s_rdata;
  logic                  err;
  logic [1:0]            err_type;
  logic [31:0]           err_addr;

  logic [31:0] base_a [SLV_NUM] = '{32'h1000_0000, 32'h1000_0100, 32'h4000_0000};
  logic [31:0] mask_a [SLV_NUM] = '{32'hF000_FF00, 32'hF000_FF00, 32'hF000_0000};

  int          n_chk;
  int          n_fail;
  logic [1:0]  m_last_et;
  logic [31:0] m_last_ea;

  nmi_if u_if ();

  nmi_demux #(
    .SLV_NUM     (SLV_NUM),
    .ADDR_BASE   ({32'h4000_0000, 32'h1000_0100, 32'h1000_0000}),
    .ADDR_MASK   ({32'hF000_0000, 32'hF000_FF00, 32'hF000_FF00}),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .ERR_RDATA   (ERR_RD)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .nmi        (u_if),
    .s_valid_o  (s_valid),
    .s_addr_o   (s_addr),
    .s_wdata_o  (s_wdata),
    .s_wstrb_o  (s_wstrb),
    .s_ready_i  (s_ready),
    .s_rdata_i  (s_rdata),
    .err_o      (err),
    .err_type_o (err_type),
    .err_addr_o (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_index(input logic [31:0] a);
    for (int i = 0; i < SLV_NUM; i++) begin
      if ((a & mask_a[i]) == base_a[i]) return i;
    end
    return -1;
  endfunction

  // Transaction outcome: valid at cycle 1, BUSY cycle k is cycle k+1, slave ready after wait_n waits.
  function automatic void model(input logic [31:0] a, input int wait_n, input logic [31:0] sd,
                                output int lat, output int vcyc, output logic [31:0] rd,
                                output logic [1:0] et);
    int idx;
    idx = exp_index(a);
    if (idx < 0) begin
      lat = 2; vcyc = 0; rd = ERR_RD; et = 2'b01;
    end else if (wait_n + 1 > TO_LIMIT) begin
      lat = TO_LIMIT + 2; vcyc = TO_LIMIT; rd = ERR_RD; et = 2'b10;
    end else begin
      lat = wait_n + 2; vcyc = wait_n + 1; rd = sd; et = 2'b00;
    end
  endfunction

  // Drives one access plus a noisy slave population; reports what was observed.
  task automatic run_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            input int wait_n, input logic [31:0] sd,
                            output int lat, output int vcyc, output int errs,
                            output logic [31:0] rd, output logic [SLV_NUM-1:0] sv_first,
                            output bit bad);
    int idx;
    idx = exp_index(a);
    lat = -1; vcyc = 0; errs = 0; rd = '0; sv_first = '0; bad = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        u_if.valid = 1'b1; u_if.addr = a; u_if.wdata = wd; u_if.wstrb = ws;
      end
      s_ready = SLV_NUM'($urandom);
      for (int i = 0; i < SLV_NUM; i++) s_rdata[i*32 +: 32] = $urandom;
      if (idx >= 0 && c >= 2) begin
        s_ready[idx] = (c - 1 > wait_n);
        if (c - 1 > wait_n) s_rdata[idx*32 +: 32] = sd;
      end
      #1;
      if (s_valid != '0) begin
        vcyc++;
        if (sv_first == '0) sv_first = s_valid;
        if (idx < 0) bad = 1'b1;
        else if (s_valid !== (SLV_NUM'(1) << idx) || s_addr !== a || s_wdata !== wd || s_wstrb !== ws)
          bad = 1'b1;
      end
      if (err) errs++;
      if (!u_if.ready && u_if.rdata !== '0) bad = 1'b1;
      if (u_if.ready) begin
        lat = c; rd = u_if.rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (s_valid !== '0) begin n_fail++; $display("FAIL rst_s_valid: got %b expected 0", s_valid); end
    n_chk++; if (s_addr !== '0) begin n_fail++; $display("FAIL rst_s_addr: got %h expected 0", s_addr); end
    n_chk++; if (s_wdata !== '0) begin n_fail++; $display("FAIL rst_s_wdata: got %h expected 0", s_wdata); end
    n_chk++; if (s_wstrb !== '0) begin n_fail++; $display("FAIL rst_s_wstrb: got %h expected 0", s_wstrb); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err); end
    n_chk++; if (err_type !== 2'b00) begin n_fail++; $display("FAIL rst_err_type: got %b expected 00", err_type); end
    n_chk++; if (err_addr !== '0) begin n_fail++; $display("FAIL rst_err_addr: got %h expected 0", err_addr); end
    n_chk++; if (u_if.ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", u_if.ready); end
    n_chk++; if (u_if.rdata !== '0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", u_if.rdata); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_decode();
    int lat, vcyc, errs; logic [31:0] rd, sd; logic [SLV_NUM-1:0] svf; bit bad;
    sd = $urandom;
    run_access(32'h1000_0104, 32'hA5A5_0001, 4'b0110, 0, sd, lat, vcyc, errs, rd, svf, bad);
    n_chk++; if (svf !== 3'b010) begin n_fail++; $display("FAIL wr_s_valid: got %b expected 010", svf); end
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d expected 2", lat); end
    n_chk++; if (vcyc !== 1) begin n_fail++; $display("FAIL wr_valid_cycles: got %0d expected 1", vcyc); end
    n_chk++; if (s_wstrb !== 4'b0110) begin n_fail++; $display("FAIL wr_wstrb: got %b expected 0110", s_wstrb); end
    n_chk++; if (s_wdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL wr_wdata: got %h expected a5a50001", s_wdata); end
    n_chk++; if (errs !== 0) begin n_fail++; $display("FAIL wr_err: got %0d pulses expected 0", errs); end
    n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL wr_protocol: got %b expected 0", bad); end
    @(negedge clk); u_if.valid = 1'b0;
  endtask

  task automatic test_read_wait();
    int lat, vcyc, errs; logic [31:0] rd; logic [SLV_NUM-1:0] svf; bit bad;
    run_access(32'h4000_0010, 32'h0, 4'h0, 3, 32'h1234_5678, lat, vcyc, errs, rd, svf, bad);
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL rd_latency: got %0d expected 5", lat); end
    n_chk++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_rdata: got %h expected 12345678", rd); end
    n_chk++; if (svf !== 3'b100) begin n_fail++; $display("FAIL rd_s_valid: got %b expected 100", svf); end
    n_chk++; if (errs !== 0) begin n_fail++; $display("FAIL rd_err: got %0d pulses expected 0", errs); end
    n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rd_protocol: got %b expected 0", bad); end
    @(negedge clk); u_if.valid = 1'b0;
  endtask

  task automatic test_decode_err();
    int lat, vcyc, errs; logic [31:0] rd; logic [SLV_NUM-1:0] svf; bit bad;
    run_access(32'h7000_0000, 32'h1, 4'hF, 0, 32'h0, lat, vcyc, errs, rd, svf, bad);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL derr_latency: got %0d expected 2", lat); end
    n_chk++; if (vcyc !== 0) begin n_fail++; $display("FAIL derr_s_valid: got %0d cycles expected 0", vcyc); end
    n_chk++; if (rd !== ERR_RD) begin n_fail++; $display("FAIL derr_rdata: got %h expected %h", rd, ERR_RD); end
    n_chk++; if (errs !== 1) begin n_fail++; $display("FAIL derr_err_pulse: got %0d expected 1", errs); end
    n_chk++; if (err_type !== 2'b01) begin n_fail++; $display("FAIL derr_err_type: got %b expected 01", err_type); end
    n_chk++; if (err_addr !== 32'h7000_0000) begin n_fail++; $display("FAIL derr_err_addr: got %h expected 70000000", err_addr); end
    m_last_et = 2'b01; m_last_ea = 32'h7000_0000;
    @(negedge clk); u_if.valid = 1'b0; #1;
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL derr_pulse_end: got %b expected 0", err); end
    n_chk++; if (u_if.ready !== 1'b0) begin n_fail++; $display("FAIL derr_ready_end: got %b expected 0", u_if.ready); end
    n_chk++; if (err_type !== 2'b01) begin n_fail++; $display("FAIL derr_type_hold: got %b expected 01", err_type); end
  endtask

`ifdef NMI_DEMUX_TIMEOUT_EN
  task automatic test_timeout();
    int lat, vcyc, errs; logic [31:0] rd, sd; logic [SLV_NUM-1:0] svf; bit bad;
    sd = $urandom;
    run_access(32'h1000_0020, 32'h5, 4'h1, 1000, sd, lat, vcyc, errs, rd, svf, bad);
    n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL to_latency: got %0d expected 9", lat); end
    n_chk++; if (vcyc !== 7) begin n_fail++; $display("FAIL to_valid_cycles: got %0d expected 7", vcyc); end
    n_chk++; if (rd !== ERR_RD) begin n_fail++; $display("FAIL to_rdata: got %h expected %h", rd, ERR_RD); end
    n_chk++; if (errs !== 1) begin n_fail++; $display("FAIL to_err_pulse: got %0d expected 1", errs); end
    n_chk++; if (err_type !== 2'b10) begin n_fail++; $display("FAIL to_err_type: got %b expected 10", err_type); end
    n_chk++; if (err_addr !== 32'h1000_0020) begin n_fail++; $display("FAIL to_err_addr: got %h expected 10000020", err_addr); end
    m_last_et = 2'b10; m_last_ea = 32'h1000_0020;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); u_if.valid = 1'b0; s_ready = 3'b001; s_rdata[31:0] = sd; #1;
      n_chk++; if (u_if.ready !== 1'b0 || s_valid !== '0 || err !== 1'b0) begin
        n_fail++; $display("FAIL to_late_ready: got ready=%b s_valid=%b err=%b expected 0/000/0", u_if.ready, s_valid, err);
      end
    end
    sd = $urandom;
    run_access(32'h1000_0040, 32'h6, 4'h2, 6, sd, lat, vcyc, errs, rd, svf, bad);
    n_chk++; if (lat !== 8) begin n_fail++; $display("FAIL to_edge_latency: got %0d expected 8", lat); end
    n_chk++; if (rd !== sd) begin n_fail++; $display("FAIL to_edge_rdata: got %h expected %h", rd, sd); end
    n_chk++; if (errs !== 0) begin n_fail++; $display("FAIL to_edge_err: got %0d expected 0", errs); end
    n_chk++; if (err_type !== 2'b10) begin n_fail++; $display("FAIL to_edge_type_hold: got %b expected 10", err_type); end
    @(negedge clk); u_if.valid = 1'b0;
  endtask
`else
  task automatic test_long_wait();
    int lat, vcyc, errs; logic [31:0] rd, sd; logic [SLV_NUM-1:0] svf; bit bad;
    sd = $urandom;
    run_access(32'h1000_0020, 32'h5, 4'h1, 12, sd, lat, vcyc, errs, rd, svf, bad);
    n_chk++; if (lat !== 14) begin n_fail++; $display("FAIL lw_latency: got %0d expected 14", lat); end
    n_chk++; if (vcyc !== 13) begin n_fail++; $display("FAIL lw_valid_cycles: got %0d expected 13", vcyc); end
    n_chk++; if (rd !== sd) begin n_fail++; $display("FAIL lw_rdata: got %h expected %h", rd, sd); end
    n_chk++; if (errs !== 0) begin n_fail++; $display("FAIL lw_err: got %0d expected 0", errs); end
    @(negedge clk); u_if.valid = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    int lat, vcyc, errs; logic [31:0] rd, sd; logic [SLV_NUM-1:0] svf; bit bad;
    sd = $urandom;
    run_access(32'h1000_0000, 32'h11, 4'h3, 0, sd, lat, vcyc, errs, rd, svf, bad);
    n_chk++; if (lat !== 2 || rd !== sd) begin n_fail++; $display("FAIL b2b_first: got lat=%0d rdata=%h expected 2/%h", lat, rd, sd); end
    sd = $urandom;
    run_access(32'h4123_4560, 32'h22, 4'hC, 0, sd, lat, vcyc, errs, rd, svf, bad);
    n_chk++; if (lat !== 2 || rd !== sd) begin n_fail++; $display("FAIL b2b_second: got lat=%0d rdata=%h expected 2/%h", lat, rd, sd); end
    n_chk++; if (svf !== 3'b100 || bad !== 1'b0) begin n_fail++; $display("FAIL b2b_select: got %b bad=%b expected 100/0", svf, bad); end
    @(negedge clk); u_if.valid = 1'b0;
  endtask

  task automatic test_random();
    int lat, vcyc, errs, w, m_lat, m_vcyc; logic [31:0] a, wd, rd, sd, m_rd; logic [3:0] ws;
    logic [1:0] m_et; logic [SLV_NUM-1:0] svf; bit bad;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       a = {4'h1, 12'($urandom), 8'h00, 8'($urandom)};
        1:       a = {4'h1, 12'($urandom), 8'h01, 8'($urandom)};
        2:       a = {4'h4, 28'($urandom)};
        default: a = $urandom;
      endcase
      wd = $urandom; ws = 4'($urandom); sd = $urandom; w = $urandom_range(0, 9);
      model(a, w, sd, m_lat, m_vcyc, m_rd, m_et);
      run_access(a, wd, ws, w, sd, lat, vcyc, errs, rd, svf, bad);
      if (m_et != 2'b00) begin m_last_et = m_et; m_last_ea = a; end
      n_chk++; if (lat !== m_lat) begin n_fail++; $display("FAIL rnd_latency[%0d]: addr=%h got %0d expected %0d", n, a, lat, m_lat); end
      n_chk++; if (vcyc !== m_vcyc) begin n_fail++; $display("FAIL rnd_valid_cycles[%0d]: got %0d expected %0d", n, vcyc, m_vcyc); end
      n_chk++; if (rd !== m_rd) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, rd, m_rd); end
      n_chk++; if (errs !== ((m_et != 2'b00) ? 1 : 0)) begin n_fail++; $display("FAIL rnd_err_pulse[%0d]: got %0d", n, errs); end
      n_chk++; if (err_type !== m_last_et || err_addr !== m_last_ea) begin
        n_fail++; $display("FAIL rnd_err_info[%0d]: got %b/%h expected %b/%h", n, err_type, err_addr, m_last_et, m_last_ea);
      end
      n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rnd_protocol[%0d]: got %b expected 0", n, bad); end
      if ($urandom_range(0, 1) == 1) begin @(negedge clk); u_if.valid = 1'b0; end
    end
    @(negedge clk); u_if.valid = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int lat, vcyc, errs; logic [31:0] rd, sd; logic [SLV_NUM-1:0] svf; bit bad;
    @(negedge clk);
    u_if.valid = 1'b1; u_if.addr = 32'h4000_0000; u_if.wdata = $urandom; u_if.wstrb = 4'hF; s_ready = '0;
    repeat (3) begin @(negedge clk); s_ready = '0; end
    #1;
    n_chk++; if (s_valid !== 3'b100) begin n_fail++; $display("FAIL mid_busy_sel: got %b expected 100", s_valid); end
    rst_n = 1'b0; #1;
    n_chk++; if (s_valid !== '0) begin n_fail++; $display("FAIL mid_rst_s_valid: got %b expected 0", s_valid); end
    n_chk++; if (s_addr !== '0 || s_wdata !== '0 || s_wstrb !== '0) begin
      n_fail++; $display("FAIL mid_rst_req: got %h/%h/%h expected 0", s_addr, s_wdata, s_wstrb);
    end
    n_chk++; if (err !== 1'b0 || err_type !== 2'b00 || err_addr !== '0) begin
      n_fail++; $display("FAIL mid_rst_err: got %b/%b/%h expected 0", err, err_type, err_addr);
    end
    n_chk++; if (u_if.ready !== 1'b0 || u_if.rdata !== '0) begin
      n_fail++; $display("FAIL mid_rst_resp: got %b/%h expected 0", u_if.ready, u_if.rdata);
    end
    @(negedge clk); u_if.valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_last_et = 2'b00; m_last_ea = '0;
    sd = $urandom;
    run_access(32'h1000_0108, 32'h33, 4'h5, 1, sd, lat, vcyc, errs, rd, svf, bad);
    n_chk++; if (lat !== 3 || rd !== sd) begin n_fail++; $display("FAIL post_rst_access: got lat=%0d rdata=%h expected 3/%h", lat, rd, sd); end
    n_chk++; if (svf !== 3'b010 || errs !== 0 || bad !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_select: got %b errs=%0d bad=%b expected 010/0/0", svf, errs, bad);
    end
    n_chk++; if (err_type !== m_last_et) begin n_fail++; $display("FAIL post_rst_err_type: got %b expected 00", err_type); end
    @(negedge clk); u_if.valid = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; m_last_et = 2'b00; m_last_ea = '0;
    rst_n = 1'b0;
    u_if.valid = 1'b0; u_if.addr = '0; u_if.wdata = '0; u_if.wstrb = '0;
    s_ready = '0; s_rdata = '0;
    test_reset();
    test_write_decode();
    test_read_wait();
    test_decode_err();
`ifdef NMI_DEMUX_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_back_to_back();
    test_random();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nmi_demux.md
NMI_DEMUX -- requirements
Module: nmi_demux

Interface
REQ-001 SHALL have parameter SLV_NUM, default 13, meaning the number of downstream NMI slaves (1..16).
REQ-002 SHALL have parameter ADDR_BASE, default all-zero, meaning a packed SLV_NUM×32 vector of per-slave base addresses.
REQ-003 SHALL have parameter ADDR_MASK, default all-zero, meaning a packed SLV_NUM×32 vector of per-slave compare masks.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the maximum BUSY cycles before abort (≥2).
REQ-005 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, meaning the rdata returned on decode error or timeout.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port nmi, nmi_if.slave: the upstream NMI port (valid, ready, addr, wdata, wstrb, rdata).
REQ-009 SHALL have port s_valid_o, output, SLV_NUM bits: per-slave valid.
REQ-010 SHALL have ports s_addr_o / s_wdata_o, output, 32 bits each, and s_wstrb_o, output, 4 bits: shared request fields.
REQ-011 SHALL have port s_ready_i, input, SLV_NUM bits: per-slave ready.
REQ-012 SHALL have port s_rdata_i, input, SLV_NUM×32 bits: per-slave rdata.
REQ-013 SHALL have port err_o, output, 1 bit: one-cycle error pulse.
REQ-014 SHALL have port err_type_o, output, 2 bits: 01 = decode, 10 = timeout.
REQ-015 SHALL have port err_addr_o, output, 32 bits: address of the last errored access.

Function
REQ-016 Slave i SHALL match when (nmi.addr & ADDR_MASK[i]) == ADDR_BASE[i]; the lowest matching index wins.
REQ-017 FSM states SHALL be IDLE, BUSY, DERR, TOUT.
REQ-018 IDLE with nmi.valid SHALL register addr, wdata, wstrb and the match index; next state is BUSY on a match, otherwise DERR.
REQ-019 In BUSY, s_valid_o[sel] SHALL be 1 and all other bits 0; s_addr_o, s_wdata_o and s_wstrb_o SHALL come from the registered request.
REQ-020 In BUSY, nmi.ready SHALL equal s_ready_i[sel] combinationally, nmi.rdata SHALL equal s_rdata_i[sel], and on ready the FSM SHALL return to IDLE.
REQ-021 Minimum latency SHALL be 2 cycles from nmi.valid to nmi.ready (1 decode cycle + 1 slave cycle for a zero-wait slave).
REQ-022 DERR SHALL assert nmi.ready=1 and nmi.rdata=ERR_RDATA for one cycle, assert err_o with err_type_o=01, load err_addr_o, then return to IDLE; no s_valid_o bit SHALL assert.
REQ-023 The timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without ready.
REQ-024 When the counter reaches TIMEOUT_CYC-1 without ready, the FSM SHALL drop s_valid_o and enter TOUT.
REQ-025 TOUT SHALL behave as DERR but with err_type_o=10.
REQ-026 If ready coincides with the terminal count, ready SHALL win: normal completion, no error.
REQ-027 Any s_ready_i bit outside BUSY, or for an unselected slave, SHALL be ignored.
REQ-028 nmi.ready SHALL be 0 in IDLE; nmi.rdata SHALL be 0 when nmi.ready is 0.
REQ-029 err_type_o and err_addr_o SHALL hold until the next error.

Reset
REQ-030 On rst_n_i low, asynchronously: state=IDLE, counter=0, s_valid_o=0, s_addr_o/s_wdata_o=0, s_wstrb_o=0, err_o=0, err_type_o=00, err_addr_o=0.
REQ-031 Reset mid-BUSY SHALL abandon the transaction with no response; the bus master is reset alongside.

Configuration
REQ-032 Macro NMI_DEMUX_TIMEOUT_EN defined: the timeout counter, TOUT state and err_type_o=10 SHALL exist as specified.
REQ-033 Macro NMI_DEMUX_TIMEOUT_EN undefined: no counter SHALL be built, TOUT SHALL be unreachable, and BUSY SHALL wait indefinitely for ready.

Verification
REQ-034 SLV_NUM=3, bases 0x1000_0000/0x1000_0100/0x4000_0000, masks 0xF000_FF00/0xF000_FF00/0xF000_0000; write 0x1000_0104 with wdata 0xA5A5_0001 -> s_valid_o=010, wstrb passed through, nmi.ready in cycle 2.
REQ-035 Read 0x4000_0010, slave 2 responding 0x1234_5678 after 3 wait cycles -> nmi.rdata=0x1234_5678, ready at cycle 5, err_o=0.
REQ-036 Access 0x7000_0000 -> no s_valid_o, nmi.rdata=0xDEAD_BEEF at cycle 2, err_o pulse, err_type_o=01, err_addr_o=0x7000_0000.
REQ-037 TIMEOUT_CYC=8, slave 0 never ready -> s_valid_o[0] high 7 cycles, then error response with err_type_o=10; a late s_ready_i[0] is ignored.
REQ-038 TIMEOUT_CYC=8, s_ready_i[0] asserted on the 7th BUSY cycle -> normal completion with slave rdata, err_o=0.
REQ-039 rst_n_i pulsed low mid-BUSY -> all outputs at reset values immediately, state IDLE; the next access completes normally.
